// File: rtl/pong_pkg.sv
// Shared types and button codes for the pong paddle path (input conditioner,
// paddle and their benches).
package pong_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      MOVE_UP   = 2'b01,
      MOVE_DOWN = 2'b10
   } dir_state_t;

   localparam logic [1:0] BTN_NONE = 2'b00;
   localparam logic [1:0] BTN_UP   = 2'b01;
   localparam logic [1:0] BTN_DOWN = 2'b10;

   // Both buttons held is a conflict and resolves to IDLE like no button.
   function automatic dir_state_t dir_decode(input logic [1:0] level);
      dir_state_t dir;
      case (level)
         2'b01:   dir = MOVE_UP;
         2'b10:   dir = MOVE_DOWN;
         default: dir = IDLE;
      endcase
      return dir;
   endfunction

endpackage

// File: rtl/paddle_input_cond_if.sv
// Button-side bundle of one paddle input conditioner: raw pins in,
// move strobes, debounced levels and moving flag out.
interface paddle_input_cond_if;

   logic [1:0] btn_raw;
   logic [1:0] btn;
   logic [1:0] btn_level;
   logic       moving;

   modport master (output btn_raw, input btn, input btn_level, input moving);
   modport slave  (input btn_raw, output btn, output btn_level, output moving);

endinterface

// File: rtl/paddle_input_cond_debounce.sv
// btn_debounce: two-flop synchroniser followed by a stable-count debouncer
// for a single button.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level
);

   localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic            sync1_r;
   logic            sync2_r;
   logic            level_r;
   logic [DB_W-1:0] cnt_r;

   // Synchronise, then accept a new level only after it has been stable long enough.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         level_r <= 1'b0;
         cnt_r   <= {DB_W{1'b0}};
      end else begin
         sync1_r <= raw;
         sync2_r <= sync1_r;
         if (sync2_r != level_r) begin
            if (cnt_r == DB_LAST) begin
               level_r <= ~level_r;
               cnt_r   <= {DB_W{1'b0}};
            end else begin
               cnt_r <= cnt_r + DB_W'(1);
            end
         end else begin
            cnt_r <= {DB_W{1'b0}};
         end
      end
   end

   assign level = level_r;

endmodule

// File: rtl/paddle_input_cond.sv
// paddle_input_cond: debounced, conflict-resolved, rate-limited paddle move strobes.
// Optional macro PADDLE_ACCEL_EN halves the strobe interval after ACCEL_PULSES strobes.
module paddle_input_cond
   import pong_pkg::*;
#(
   parameter int CLOCK_SPEED     = 50000000,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int MOVE_PERIOD     = 100000,
   parameter int ACCEL_PULSES    = 64
) (
   input  logic                clk,
   input  logic                rst,
   paddle_input_cond_if.slave  bus
);

   localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > MOVE_PERIOD) ? DEBOUNCE_CYCLES : MOVE_PERIOD;
   localparam int CNT_WIDTH  = $clog2(MAX_CYCLES) + 1;
   localparam logic [CNT_WIDTH-1:0] PERIOD_LAST = CNT_WIDTH'(MOVE_PERIOD - 1);

   if (CLOCK_SPEED < 1 || DEBOUNCE_CYCLES < 2 || MOVE_PERIOD < 2 || ACCEL_PULSES < 1) begin : g_param_check
      $error("paddle_input_cond: illegal parameter value");
   end

   logic [1:0]           level_s;
   dir_state_t           state_r;
   dir_state_t           state_nxt_s;
   logic [CNT_WIDTH-1:0] rate_cnt_r;
   logic [CNT_WIDTH-1:0] rate_cnt_nxt_s;
   logic [CNT_WIDTH-1:0] interval_last_s;
   logic                 strobe_s;
   logic [1:0]           btn_nxt_s;
   logic [1:0]           btn_r;
   logic                 moving_r;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
      .clk(clk), .rst(rst), .raw(bus.btn_raw[0]), .level(level_s[0])
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
      .clk(clk), .rst(rst), .raw(bus.btn_raw[1]), .level(level_s[1])
   );

   // Next state from debounced levels; entry strobes at once, holds strobe on interval expiry.
   always_comb begin
      state_nxt_s    = dir_decode(level_s);
      rate_cnt_nxt_s = rate_cnt_r;
      strobe_s       = 1'b0;
      btn_nxt_s      = BTN_NONE;
      if (state_nxt_s != state_r) begin
         rate_cnt_nxt_s = {CNT_WIDTH{1'b0}};
         strobe_s       = (state_nxt_s != IDLE);
      end else if (state_r != IDLE) begin
         if (rate_cnt_r == interval_last_s) begin
            rate_cnt_nxt_s = {CNT_WIDTH{1'b0}};
            strobe_s       = 1'b1;
         end else begin
            rate_cnt_nxt_s = rate_cnt_r + CNT_WIDTH'(1);
         end
      end else begin
         rate_cnt_nxt_s = {CNT_WIDTH{1'b0}};
      end
      if (strobe_s) begin
         btn_nxt_s = (state_nxt_s == MOVE_UP) ? BTN_UP : BTN_DOWN;
      end else begin
         btn_nxt_s = BTN_NONE;
      end
   end

   // State, rate counter and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r    <= IDLE;
         rate_cnt_r <= {CNT_WIDTH{1'b0}};
         btn_r      <= BTN_NONE;
         moving_r   <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         rate_cnt_r <= rate_cnt_nxt_s;
         btn_r      <= btn_nxt_s;
         moving_r   <= (state_nxt_s != IDLE);
      end
   end

`ifdef PADDLE_ACCEL_EN
   localparam logic [CNT_WIDTH-1:0] HALF_LAST = CNT_WIDTH'((MOVE_PERIOD >> 1) - 1);
   logic [15:0] strb_cnt_r;

   always_comb begin
      interval_last_s = (strb_cnt_r >= 16'(ACCEL_PULSES)) ? HALF_LAST : PERIOD_LAST;
   end

   // Saturating count of strobes issued in the current hold; the entry strobe counts as one.
   always_ff @(posedge clk) begin
      if (!rst) begin
         strb_cnt_r <= 16'd0;
      end else if (state_nxt_s != state_r) begin
         strb_cnt_r <= strobe_s ? 16'd1 : 16'd0;
      end else if (strobe_s && (strb_cnt_r != 16'hFFFF)) begin
         strb_cnt_r <= strb_cnt_r + 16'd1;
      end else begin
         strb_cnt_r <= strb_cnt_r;
      end
   end
`else
   assign interval_last_s = PERIOD_LAST;
`endif

   assign bus.btn       = btn_r;
   assign bus.btn_level = level_s;
   assign bus.moving    = moving_r;

endmodule

// File: tb/tb_paddle_input_cond.sv
// Randomised and directed bench for paddle_input_cond against a cycle-level
// behavioural model (DEBOUNCE_CYCLES=4, MOVE_PERIOD=8, ACCEL_PULSES=3).
module tb_paddle_input_cond;

   localparam int DB = 4;
   localparam int MP = 8;
   localparam int AP = 3;
`ifdef PADDLE_ACCEL_EN
   localparam bit ACCEL = 1'b1;
`else
   localparam bit ACCEL = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   paddle_input_cond_if bus ();

   paddle_input_cond #(
      .CLOCK_SPEED(50000000), .DEBOUNCE_CYCLES(DB), .MOVE_PERIOD(MP), .ACCEL_PULSES(AP)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   bit chk_en   = 1'b0;

   // model state: sync pipe, stable run length, levels, direction, cycles since strobe
   logic [1:0] m_s1 = 2'b00, m_s2 = 2'b00, m_lvl = 2'b00, m_btn = 2'b00;
   int         m_run[2] = '{0, 0};
   int         m_dir = 0, m_since = 0, m_strb = 0;
   logic       m_mov = 1'b0;

   task automatic model_step(input logic [1:0] raw_v, input logic rst_v);
      logic [1:0] old_lvl, old_s2;
      int d, intv;
      if (!rst_v) begin
         m_s1 = 2'b00; m_s2 = 2'b00; m_lvl = 2'b00; m_btn = 2'b00; m_mov = 1'b0;
         m_run[0] = 0; m_run[1] = 0; m_dir = 0; m_since = 0; m_strb = 0;
      end else begin
         old_lvl = m_lvl;
         old_s2  = m_s2;
         d = (old_lvl == 2'b01) ? 1 : (old_lvl == 2'b10) ? 2 : 0;
         m_btn = 2'b00;
         if (d != m_dir) begin
            m_since = 0;
            m_strb  = (d != 0) ? 1 : 0;
            m_btn   = 2'(d);
         end else if (d != 0) begin
            m_since++;
            intv = (ACCEL && m_strb >= AP) ? MP / 2 : MP;
            if (m_since == intv) begin
               m_btn   = 2'(d);
               m_since = 0;
               if (m_strb < 65535) m_strb++;
            end
         end
         m_mov = (d != 0);
         m_dir = d;
         for (int b = 0; b < 2; b++) begin
            if (old_s2[b] != old_lvl[b]) begin
               m_run[b]++;
               if (m_run[b] == DB) begin
                  m_lvl[b] = ~m_lvl[b];
                  m_run[b] = 0;
               end
            end else begin
               m_run[b] = 0;
            end
         end
         m_s2 = m_s1;
         m_s1 = raw_v;
      end
   endtask

   task automatic step(input logic [1:0] raw_v, input logic rst_v);
      bus.btn_raw = raw_v;
      rst = rst_v;
      @(posedge clk);
      model_step(raw_v, rst_v);
      cyc++;
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         n_checks += 3;
         if (bus.btn !== m_btn) begin
            n_err++;
            $display("FAIL btn: got %b expected %b (cycle %0d)", bus.btn, m_btn, cyc);
         end
         if (bus.btn_level !== m_lvl) begin
            n_err++;
            $display("FAIL btn_level: got %b expected %b (cycle %0d)", bus.btn_level, m_lvl, cyc);
         end
         if (bus.moving !== m_mov) begin
            n_err++;
            $display("FAIL moving: got %b expected %b (cycle %0d)", bus.moving, m_mov, cyc);
         end
      end
   end

   initial begin
      int t0, lvl_at, lc, fs, late_up, cnt11, glitch_seen;
      int q[$];
      int exp_up[$];
      logic [1:0] r;

      if (ACCEL) exp_up = '{7, 15, 23, 27, 31, 35, 39};
      else       exp_up = '{7, 15, 23, 31, 39};
      bus.btn_raw = 2'b11;
      chk_en = 1'b1;

      // 1: reset with both buttons pressed
      step(2'b11, 1'b0);
      step(2'b11, 1'b0);
      chk("rst_btn", int'(bus.btn), 0);
      chk("rst_level", int'(bus.btn_level), 0);
      chk("rst_moving", int'(bus.moving), 0);
      for (int i = 0; i < 8; i++) step(2'b00, 1'b1);
      chk("idle_level", int'(bus.btn_level), 0);

      // 2: hold up for 40 cycles
      t0 = cyc; lvl_at = -1;
      for (int i = 0; i < 40; i++) begin
         step(2'b01, 1'b1);
         if (bus.btn_level == 2'b01 && lvl_at < 0) lvl_at = cyc - t0;
         if (bus.btn == 2'b01) q.push_back(cyc - t0);
      end
      chk("up_level_latency", lvl_at, 6);
      chk("up_strobe_count", q.size(), exp_up.size());
      foreach (exp_up[i]) chk("up_strobe_time", (i < q.size()) ? q[i] : -1, exp_up[i]);

      // 4: direct switch up -> down mid-interval
      lc = -1; fs = -1; late_up = 0;
      for (int i = 0; i < 30; i++) begin
         step(2'b10, 1'b1);
         if (lc >= 0 && bus.btn == 2'b01) late_up++;
         if (bus.btn == 2'b10 && fs < 0) fs = cyc;
         if (bus.btn_level == 2'b10 && lc < 0) lc = cyc;
      end
      chk("switch_first_down_delay", fs - lc, 1);
      chk("switch_late_up_strobes", late_up, 0);

      // 5: conflict then release to down
      for (int i = 0; i < 5; i++) step(2'b01, 1'b1);
      cnt11 = 0;
      for (int i = 0; i < 20; i++) begin
         step(2'b11, 1'b1);
         if (bus.btn_level == 2'b11 && bus.btn != 2'b00) cnt11++;
      end
      chk("conflict_strobes", cnt11, 0);
      chk("conflict_moving", int'(bus.moving), 0);
      for (int i = 0; i < 20; i++) step(2'b10, 1'b1);

      // 3: short glitch on the down button from idle
      for (int i = 0; i < 12; i++) step(2'b00, 1'b1);
      glitch_seen = 0;
      for (int i = 0; i < 15; i++) begin
         step((i < 3) ? 2'b10 : 2'b00, 1'b1);
         if (bus.btn_level != 2'b00 || bus.btn != 2'b00) glitch_seen++;
      end
      chk("glitch_ignored", glitch_seen, 0);

      // 6: hold down, check acceleration, then reset mid-hold
      q.delete();
      for (int i = 0; i < 50; i++) begin
         step(2'b10, 1'b1);
         if (bus.btn == 2'b10) q.push_back(cyc);
      end
      chk("accel_gap1", (q.size() > 1) ? q[1] - q[0] : -1, 8);
      chk("accel_gap2", (q.size() > 2) ? q[2] - q[1] : -1, 8);
      chk("accel_gap3", (q.size() > 3) ? q[3] - q[2] : -1, ACCEL ? 4 : 8);
      step(2'b10, 1'b0);
      chk("midhold_rst_btn", int'(bus.btn), 0);
      chk("midhold_rst_moving", int'(bus.moving), 0);

      // random segments with occasional reset
      for (int s = 0; s < 600; s++) begin
         r = 2'($urandom_range(0, 3));
         for (int i = 0; i < int'($urandom_range(1, 14)); i++) begin
            step(r, ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1);
         end
      end
      chk_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/paddle_input_cond.md
Name: paddle_input_cond

Overview:
Conditions the raw paddle push-buttons into the 2-bit btn code consumed by paddle.
- Synchronises both inputs, debounces them and resolves conflicting presses.
- Issues rate-limited single-cycle move strobes, so paddle steps once per strobe instead of once per clock.
- Sits between the board button pins and paddle.btn; one instance per player.

Parameters:
CLOCK_SPEED, 50000000, system clock frequency in Hz (documentation and derivation only).
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new button level (20 ms at 50 MHz); minimum 2.
MOVE_PERIOD, 100000, cycles between move strobes while a direction is held; minimum 2.
ACCEL_PULSES, 64, strobes in one continuous hold before acceleration (used only with ACCEL_EN).
CNT_WIDTH, $clog2(max(DEBOUNCE_CYCLES, MOVE_PERIOD))+1, counter width (derived localparam).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-low; sampled on the clk rising edge.
btn_raw  input  2  asynchronous raw buttons, active-high; bit0 = up (+DY), bit1 = down.
btn  output  2  to paddle.btn; 2'b00 idle, 2'b01 one-cycle up strobe, 2'b10 one-cycle down strobe; never 2'b11.
btn_level  output  2  debounced button levels, for status LEDs.
moving  output  1  high while in the MOVE_UP or MOVE_DOWN state.

Behaviour:
- Reset (rst==0 at a clk edge): sync flops, btn_level, btn, moving and all counters are 0; FSM = IDLE. Reset mid-hold drops any strobe that same edge.
- Synchroniser: two flops per bit; no logic between the stages.
- Debounce, per bit:
  - Counter increments while the synced value differs from btn_level.
  - Counter clears to 0 on any cycle they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch still present, btn_level toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never reaches btn_level.
  - Latency from a clean raw change to btn_level change: 2 + DEBOUNCE_CYCLES cycles.
- FSM states, decoded from btn_level:
  - IDLE: entered on level 00 or 11.
  - MOVE_UP: entered on level 01.
  - MOVE_DOWN: entered on level 10.
  - 11 (both pressed) is a conflict: forces IDLE, no strobes.
- Rate counter:
  - Cleared on every state change.
  - Entering MOVE_UP/MOVE_DOWN issues a strobe on the cycle after btn_level changes, i.e. a registered 1-cycle latency.
  - Further strobes follow every MOVE_PERIOD cycles while the state holds; strobe spacing is exactly MOVE_PERIOD.
  - btn is 00 on all other cycles.
- Direct MOVE_UP <-> MOVE_DOWN change: no strobe in the old direction after the level change; strobe in the new direction the next cycle; counter restarts.
- Return to IDLE: btn = 00 from the cycle after the level change; no trailing strobe.
- moving is a registered decode of the FSM state, asserted the same cycle as the first strobe.

Optional Feature:
Macro PADDLE_ACCEL_EN.
- Defined:
  - A 16-bit saturating strobe counter counts strobes in the current hold.
  - Once it reaches ACCEL_PULSES, the strobe interval becomes MOVE_PERIOD>>1, taking effect from the interval after the ACCEL_PULSES-th strobe.
  - The strobe counter clears on any state change or reset.
- Undefined: the interval is always MOVE_PERIOD; no strobe counter is synthesised.

Decomposition:
- Package pong_pkg:
  - typedef enum logic [1:0] dir_state_t {IDLE, MOVE_UP, MOVE_DOWN}.
  - Constants BTN_NONE=2'b00, BTN_UP=2'b01, BTN_DOWN=2'b10.
  - Shared with paddle and its bench.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, raw, level): contains the synchroniser and debounce counter; instantiated twice. The top holds the FSM, rate counter and optional accel logic.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, MOVE_PERIOD=8, ACCEL_PULSES=3.
1. rst=0 for 2 cycles with btn_raw=11 -> btn=00, btn_level=00, moving=0; after release, outputs stay 0 until debounce completes.
2. btn_raw 00->01 held 40 cycles -> btn_level=01 at cycle 6; btn=01 at cycle 7, 15, 23, 31, 39; btn=00 otherwise; paddle yPos 240->245.
3. 3-cycle pulse on btn_raw[1] -> btn_level and btn never change.
4. Hold 01, then switch to 10 mid-interval -> no further 01 strobes after btn_level changes; one 10 strobe the following cycle; then 10 every 8 cycles.
5. Hold 01, then add bit1 (11) -> FSM IDLE, btn=00 continuously; drop bit0 -> 10 strobes begin.
6. PADDLE_ACCEL_EN defined, hold 10 -> first 3 strobes spaced 8 cycles, then spaced 4; undefined -> all spaced 8. Also assert rst=0 mid-hold -> strobes stop that edge.
